mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port system RAM between the CPU memory path (driven by the control unit's Read/Write strobes via MAR/MDR) and the program-loader/debug port. It grants one requester at a time and sequences the RAM access. Its ack handshake lets the control unit stall its memory states until data is ready. Ties between the two ports are resolved round-robin so neither port starves.

## Interface
Parameters:
- ADDR_W, 9: RAM address width.
- DATA_W, 32: data width.
- RD_LAT, 1: RAM read latency in cycles. Legal range is 1..4; other values are a compile-time error.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ack=1 on a read.
- ld_req, ld_we, ld_addr, ld_wdata, ld_ack, ld_rdata: loader port, same widths and semantics as the cpu_* signals.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable; qualified by ram_en.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after the ram_en cycle.
- busy  out  1  high while any transaction is in flight.
- owner  out  1  current or last grant: 0 = CPU, 1 = loader.

## Operation
- **State machine:** IDLE → ISSUE → WAIT → DONE → IDLE.
  - WAIT is entered only for reads and lasts exactly RD_LAT cycles.
  - Writes go ISSUE → DONE directly.
- **IDLE:**
  - Samples cpu_req and ld_req.
  - If only one is high, that port is granted.
  - If both are high, grant the port that did not receive the previous grant (last_owner).
  - On grant, latch we/addr/wdata of the granted port, set owner, and go to ISSUE.
  - With no request, stay in IDLE.
- **ISSUE:** ram_en=1 and ram_we=latched we for exactly this one cycle. ram_addr and ram_wdata come from the latched copies.
- **WAIT:**
  - A 3-bit counter runs from RD_LAT-1 down to 0.
  - At the edge that ends the last WAIT cycle, ram_rdata is captured into the owner's rdata register.
- **DONE:**
  - The owner's ack=1 for this one cycle.
  - last_owner is updated to owner.
  - Next state is IDLE.
- **Requester rule:** the requester keeps req and its operands stable until it sees ack, and deasserts req at the edge ending the ack cycle. Because the arbiter only samples requests in IDLE, a req still high in IDLE starts a new transaction.
- **Operand latching:** operand changes after the grant edge are ignored.
- **Read data registers:** cpu_rdata and ld_rdata update only on a completed read of that port, and hold their value otherwise (including across writes).
- **Outputs outside ISSUE:** ram_en=0 and ram_we=0. ram_addr and ram_wdata hold their latched values.
- **Port isolation:** the non-owner port's ack is never asserted. Exactly one ack pulse occurs per transaction.

## Timing
- **Reset values** (Reset_n low, asynchronous):
  - state=IDLE.
  - All acks, ram_en, ram_we and busy = 0.
  - ram_addr, ram_wdata, cpu_rdata, ld_rdata = 0.
  - owner=0.
  - last_owner=1, so the CPU wins the first tie.
- **Reset mid-operation:** ram_en and ack drop immediately. No ack is issued for the aborted transaction. After Reset_n rises, the next IDLE sample starts fresh.
- **Latency:** with req first seen high in IDLE cycle c:
  - ram_en is high in cycle c+1.
  - Write ack is in c+2.
  - Read ack is in c+2+RD_LAT.
- **Throughput:** back-to-back transactions cost 3 cycles per write and RD_LAT+3 cycles per read.
- **busy:** high in ISSUE, WAIT and DONE; low in IDLE.

## Test plan
- Reset: drive Reset_n low mid-clock with random inputs → all outputs 0 and owner=0 asynchronously. The first CPU request after release is granted normally.
- CPU read, RD_LAT=1: RAM[0x005]=0xDEADBEEF, cpu_req with cpu_we=0 and addr 0x005 seen in cycle c → ram_en=1, ram_we=0, ram_addr=0x005 in c+1. cpu_ack=1 with cpu_rdata=0xDEADBEEF in c+3 only. ld_ack stays 0.
- Loader write: ld_addr=0x1FF, ld_wdata=0x12345678 in cycle c → ram_en=1 and ram_we=1 in c+1, ld_ack in c+2. A subsequent CPU read of 0x1FF returns 0x12345678. ld_rdata is unchanged.
- Contention: cpu_req and ld_req held high continuously (reads) → grant order CPU, LD, CPU, LD. Exactly one ack per transaction, acks spaced RD_LAT+3 cycles apart, owner toggling.
- RD_LAT=3 read with operand change: change cpu_addr from 0x010 to 0x020 in cycle c+1 → ram_addr stays 0x010. cpu_ack is in c+5 with RAM[0x010] data.
- Abort: assert Reset_n low during WAIT → ram_en=0 and busy=0 immediately, no ack ever issued for that access. The next request after release completes with correct latency.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one of two requesters (CPU path, loader/debug port) access to a
// single-port RAM and sequences the access, breaking ties round-robin.
module mem_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset_n,

    // Handshake (both ports): the requester raises req with stable we/addr/wdata and
    // holds them until it sees a one-cycle ack; req is dropped at the edge ending the ack
    // cycle. Requests are sampled only in IDLE, and operands are latched on the grant edge.
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,

    output logic              busy,
    output logic              owner,
    output logic [1:0]        state_dbg
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_rd_lat_check
        $error("mem_arbiter: RD_LAT must be in the range 1..4");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] wait_cnt;
    logic       last_owner;
    logic       lat_we;
    logic       grant_cpu;
    logic       grant_ld;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        grant_cpu = 1'b0;
        grant_ld  = 1'b0;
        if (cpu_req && ld_req) begin
            grant_cpu = last_owner;
            grant_ld  = !last_owner;
        end else begin
            grant_cpu = cpu_req;
            grant_ld  = ld_req;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        busy      = 1'b1;
        cpu_ack   = 1'b0;
        ld_ack    = 1'b0;
        state_dbg = state;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (grant_cpu || grant_ld) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ram_en    = 1'b1;
                ram_we    = lat_we;
                state_nxt = lat_we ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == 3'd0) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                cpu_ack   = !owner;
                ld_ack    = owner;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            lat_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            wait_cnt   <= 3'd0;
            cpu_rdata  <= '0;
            ld_rdata   <= '0;
        end else begin
            if (state == ST_IDLE && (grant_cpu || grant_ld)) begin
                owner     <= grant_ld;
                lat_we    <= grant_ld ? ld_we    : cpu_we;
                ram_addr  <= grant_ld ? ld_addr  : cpu_addr;
                ram_wdata <= grant_ld ? ld_wdata : cpu_wdata;
            end

            if (state == ST_ISSUE) begin
                wait_cnt <= WAIT_INIT;
            end else if (state == ST_WAIT && wait_cnt != 3'd0) begin
                wait_cnt <= wait_cnt - 3'd1;
            end

            // RAM data is valid in the final WAIT cycle; capture it for the owning port only.
            if (state == ST_WAIT && wait_cnt == 3'd0) begin
                if (owner) begin
                    ld_rdata <= ram_rdata;
                end else begin
                    cpu_rdata <= ram_rdata;
                end
            end

            if (state == ST_DONE) begin
                last_owner <= owner;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one RD_LAT=1 instance for the main flow and one RD_LAT=3
// instance for operand latching, both backed by a bench RAM model.
module tb_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          Clock;
    logic          Reset_n;

    logic          cpu_req, cpu_we, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          ld_req, ld_we, ld_ack;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata, ld_rdata;
    logic          ram_en, ram_we, busy, owner;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [1:0]    state_dbg;

    logic          cpu_req_b, cpu_we_b, cpu_ack_b;
    logic [AW-1:0] cpu_addr_b;
    logic [DW-1:0] cpu_wdata_b, cpu_rdata_b;
    logic          ld_req_b, ld_we_b, ld_ack_b;
    logic [AW-1:0] ld_addr_b;
    logic [DW-1:0] ld_wdata_b, ld_rdata_b;
    logic          ram_en_b, ram_we_b, busy_b, owner_b;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_wdata_b, ram_rdata_b;
    logic [1:0]    state_dbg_b;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy), .owner(owner), .state_dbg(state_dbg)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_b (
        .Clock(Clock), .Reset_n(Reset_n),
        .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b),
        .cpu_ack(cpu_ack_b), .cpu_rdata(cpu_rdata_b),
        .ld_req(ld_req_b), .ld_we(ld_we_b), .ld_addr(ld_addr_b), .ld_wdata(ld_wdata_b),
        .ld_ack(ld_ack_b), .ld_rdata(ld_rdata_b),
        .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
        .ram_rdata(ram_rdata_b), .busy(busy_b), .owner(owner_b), .state_dbg(state_dbg_b)
    );

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of run, required finish before 500000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- RAM model (shared array, per-instance read pipelines) ----------------
    logic [DW-1:0] ram [512];
    logic [DW-1:0] pipe_a;
    logic [DW-1:0] pipe_b [3];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    always @(posedge Clock) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (ram_en && ram_we) ram[ram_addr] <= ram_wdata;
        pipe_a    <= (ram_en && !ram_we) ? ram[ram_addr] : '0;
        pipe_b[0] <= (ram_en_b && !ram_we_b) ? ram[ram_addr_b] : '0;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign ram_rdata   = pipe_a;
    assign ram_rdata_b = pipe_b[2];

    // ---------------- ack monitor ----------------
    int cpu_ack_n = 0, ld_ack_n = 0, cpu_ack_b_n = 0, ld_ack_b_n = 0;
    bit both_ack = 1'b0;
    always @(negedge Clock) begin
        if (cpu_ack) cpu_ack_n++;
        if (ld_ack) ld_ack_n++;
        if (cpu_ack && ld_ack) both_ack = 1'b1;
        if (cpu_ack_b) cpu_ack_b_n++;
        if (ld_ack_b) ld_ack_b_n++;
    end

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int miscompares = 0;
    logic [33:0]   exp_q[$];             // {is_ld, is_write, read data}
    logic [DW-1:0] shadow [512];
    logic [DW-1:0] m_cpu_rd, m_ld_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge Clock); #1;
        bd_we = 1'b0;
        shadow[a] = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " cpu_ack"}, cpu_ack, 0);
        chk({tag, " ld_ack"}, ld_ack, 0);
        chk({tag, " ram_en"}, ram_en, 0);
        chk({tag, " ram_we"}, ram_we, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " owner"}, owner, 0);
        chk({tag, " ram_addr"}, ram_addr, 0);
        chk({tag, " ram_wdata"}, ram_wdata, 0);
        chk({tag, " cpu_rdata"}, cpu_rdata, 0);
        chk({tag, " ld_rdata"}, ld_rdata, 0);
        chk({tag, " state"}, state_dbg, 0);
    endtask

    // Single transaction on the RD_LAT=1 instance; starts and ends 1 ns after a rising edge in IDLE.
    task automatic txn(input bit ld, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input string tag);
        int lat, exp_lat, c0, l0;
        bit seen;
        logic [33:0] e;
        exp_lat = we ? 2 : 3;
        if (ld) begin ld_req = 1'b1; ld_we = we; ld_addr = a; ld_wdata = wd; end
        else begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
        exp_q.push_back({ld, we, we ? 32'h0 : shadow[a]});
        if (we) shadow[a] = wd;
        c0 = cpu_ack_n; l0 = ld_ack_n;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge Clock); #1;
            lat++;
            if (lat == 1) begin
                chk({tag, " ram_en"}, ram_en, 1);
                chk({tag, " ram_we"}, ram_we, we);
                chk({tag, " ram_addr"}, ram_addr, a);
                if (we) chk({tag, " ram_wdata"}, ram_wdata, wd);
            end
            if (ld ? ld_ack : cpu_ack) seen = 1'b1;
        end
        chk({tag, " ack_latency"}, lat, exp_lat);
        chk({tag, " owner"}, owner, ld);
        cpu_req = 1'b0; ld_req = 1'b0;
        e = exp_q.pop_front();
        if (!e[32]) begin
            if (e[33]) m_ld_rd = e[31:0];
            else m_cpu_rd = e[31:0];
        end
        chk({tag, " cpu_rdata"}, cpu_rdata, m_cpu_rd);
        chk({tag, " ld_rdata"}, ld_rdata, m_ld_rd);
        @(posedge Clock); #1;
        chk({tag, " cpu_ack_count"}, cpu_ack_n - c0, ld ? 0 : 1);
        chk({tag, " ld_ack_count"}, ld_ack_n - l0, ld ? 1 : 0);
        chk({tag, " busy_idle"}, busy, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc, acks, last_cyc, lat, c0, l0;
        bit seen;
        logic [33:0] e;

        Reset_n = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
        cpu_req_b = 0; cpu_we_b = 0; cpu_addr_b = '0; cpu_wdata_b = '0;
        ld_req_b = 0; ld_we_b = 0; ld_addr_b = '0; ld_wdata_b = '0;
        bd_we = 0; bd_addr = '0; bd_data = '0;
        m_cpu_rd = '0; m_ld_rd = '0;

        #2 Reset_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge Clock);
        @(negedge Clock) Reset_n = 1'b1;
        @(posedge Clock); #1;

        // random traffic, then reset asserted mid-clock with inputs still random
        for (int i = 0; i < 10; i++) begin
            cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = 9'($urandom_range(1, 511)); cpu_wdata = $urandom;
            ld_req = 1'($urandom_range(0, 1)); ld_we = 1'($urandom_range(0, 1));
            ld_addr = 9'($urandom_range(1, 511)); ld_wdata = $urandom;
            @(posedge Clock); #1;
        end
        #2 Reset_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        cpu_req = 0; ld_req = 0; cpu_we = 0; ld_we = 0;
        @(posedge Clock); #1;
        check_reset_outputs("held_reset");
        @(negedge Clock) Reset_n = 1'b1;
        @(posedge Clock); #1;

        preload(9'h005, 32'hDEADBEEF);
        preload(9'h010, 32'hA5A50010);
        preload(9'h020, 32'h0BAD0020);

        txn(1'b0, 1'b0, 9'h005, 32'h0, "cpu_rd_005");
        txn(1'b1, 1'b1, 9'h1FF, 32'h12345678, "ld_wr_1ff");
        txn(1'b0, 1'b0, 9'h1FF, 32'h0, "cpu_rd_1ff");
        txn(1'b0, 1'b1, 9'h040, 32'h40404040, "cpu_wr_040");
        txn(1'b1, 1'b0, 9'h040, 32'h0, "ld_rd_040");

        // contention: both ports hold read requests; last grant was the loader, so CPU first
        cpu_we = 0; cpu_addr = 9'h005; ld_we = 0; ld_addr = 9'h1FF;
        exp_q.push_back({1'b0, 1'b0, shadow[9'h005]});
        exp_q.push_back({1'b1, 1'b0, shadow[9'h1FF]});
        exp_q.push_back({1'b0, 1'b0, shadow[9'h005]});
        exp_q.push_back({1'b1, 1'b0, shadow[9'h1FF]});
        cpu_req = 1; ld_req = 1;
        cyc = 0; acks = 0; last_cyc = 0;
        while (acks < 4 && cyc < 60) begin
            @(posedge Clock); #1;
            cyc++;
            if (cpu_ack || ld_ack) begin
                if (exp_q.size() == 0) begin
                    chk("contend extra_ack", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("contend ack_port", {ld_ack, cpu_ack}, e[33] ? 2'b10 : 2'b01);
                    chk("contend owner", owner, e[33]);
                    chk("contend rdata", e[33] ? ld_rdata : cpu_rdata, e[31:0]);
                    if (e[33]) m_ld_rd = e[31:0];
                    else m_cpu_rd = e[31:0];
                end
                if (acks == 0) chk("contend first_latency", cyc, 3);
                else chk("contend ack_spacing", cyc - last_cyc, 4);
                last_cyc = cyc;
                acks++;
                if (acks == 4) begin cpu_req = 0; ld_req = 0; end
            end
        end
        chk("contend ack_total", acks, 4);
        cpu_req = 0; ld_req = 0;
        @(posedge Clock); #1;
        chk("contend idle_after", busy, 0);

        // abort: reset asserted during the WAIT cycle of a CPU read
        c0 = cpu_ack_n; l0 = ld_ack_n;
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h040;
        @(posedge Clock); #1;
        chk("abort issue ram_en", ram_en, 1);
        @(posedge Clock); #1;
        chk("abort in_wait state", state_dbg, 2);
        chk("abort in_wait busy", busy, 1);
        #2 Reset_n = 1'b0;
        #1;
        chk("abort ram_en", ram_en, 0);
        chk("abort busy", busy, 0);
        chk("abort cpu_ack", cpu_ack, 0);
        cpu_req = 0;
        m_cpu_rd = '0; m_ld_rd = '0;
        @(negedge Clock) Reset_n = 1'b1;
        repeat (6) @(posedge Clock);
        #1;
        chk("abort no_cpu_ack", cpu_ack_n - c0, 0);
        chk("abort no_ld_ack", ld_ack_n - l0, 0);
        txn(1'b0, 1'b0, 9'h005, 32'h0, "post_abort_rd");

        // RD_LAT=3 instance: operand change after grant must be ignored
        c0 = ld_ack_b_n;
        cpu_req_b = 1; cpu_we_b = 0; cpu_addr_b = 9'h010;
        exp_q.push_back({1'b0, 1'b0, shadow[9'h010]});
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge Clock); #1;
            lat++;
            if (lat == 1) begin
                cpu_addr_b = 9'h020;
                chk("lat3 ram_en", ram_en_b, 1);
                chk("lat3 ram_addr_issue", ram_addr_b, 9'h010);
            end
            if (lat == 3) begin
                chk("lat3 ram_addr_wait", ram_addr_b, 9'h010);
                chk("lat3 ram_en_wait", ram_en_b, 0);
            end
            if (cpu_ack_b) seen = 1'b1;
        end
        cpu_req_b = 0;
        chk("lat3 ack_latency", lat, 5);
        e = exp_q.pop_front();
        chk("lat3 cpu_rdata", cpu_rdata_b, e[31:0]);
        chk("lat3 ld_rdata", ld_rdata_b, 0);
        @(posedge Clock); #1;
        chk("lat3 no_ld_ack", ld_ack_b_n - c0, 0);

        chk("never_both_acks", both_ack, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
